div_man_iter: RTL



---
 rtl/div_man_iter_if.sv | 36 +++
 rtl/div_man_iter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/div_man_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : div_man_iter_if
// Purpose  : Handshake bundle for the iterative mantissa divider. It carries
//            the operand channel (in_valid/in_ready/op1/op2) and the result
//            channel (out_valid/out_ready/result/div_zero/ovf/inexact).
// Modports : master - the side that issues operands and consumes results
//            slave  - the divider itself
// Revision : 1.0 - initial release
// ============================================================================
interface div_man_iter_if #(
  parameter int MAN_W = 12,
  parameter int Q_W   = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [MAN_W-1:0] op1;
  logic [MAN_W-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [Q_W-1:0]   result;
  logic             div_zero;
  logic             ovf;
  logic             inexact;

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, result, div_zero, ovf, inexact
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, result, div_zero, ovf, inexact
  );
endinterface
`default_nettype wire

// File: rtl/div_man_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_man_iter
// Purpose  : Iterative restoring divider for unsigned mantissas. Produces
//            Q = floor(op1 * 2^(Q_W-1) / op2) (1 integer bit, Q_W-1 fraction
//            bits), one quotient bit per clock.
// Ports    : clk        - clock
//            rst_n      - asynchronous active-low reset
//            bus.slave  - operand channel  : in_valid, in_ready, op1, op2
//                         result channel   : out_valid, out_ready, result,
//                                            div_zero, ovf, inexact
// Revision : 1.0 - initial release
// ============================================================================
module div_man_iter #(
  parameter int MAN_W = 12,
  parameter int Q_W   = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  div_man_iter_if.slave bus
);

  localparam int CNT_W = $clog2(Q_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [MAN_W:0]   rem_q,   rem_d;
  logic [MAN_W-1:0] div_q,   div_d;
  logic [Q_W-1:0]   quot_q,  quot_d;
  logic             dz_q,    dz_d;
  logic             ovf_q,   ovf_d;
  logic             inx_q,   inx_d;

  logic [MAN_W:0]   w_div_ext;
  logic             w_ge;
  logic [MAN_W:0]   w_rem_sub;
  logic [MAN_W:0]   w_rem_shl;
  logic             w_in_dz;
  logic             w_in_ovf;

  // One restoring step. The remainder is always below the divisor after the
  // conditional subtract, so the left shift cannot lose the MSB.
  assign w_div_ext = {1'b0, div_q};
  assign w_ge      = (rem_q >= w_div_ext);
  assign w_rem_sub = w_ge ? (rem_q - w_div_ext) : rem_q;
  assign w_rem_shl = {w_rem_sub[MAN_W-1:0], 1'b0};

  // Accept-time special cases. op1 >= 2*op2 would need a second integer
  // quotient bit, so it saturates instead.
  assign w_in_dz  = (bus.op2 == '0);
  assign w_in_ovf = ({1'b0, bus.op1} >= {bus.op2, 1'b0});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quot_d  = quot_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    inx_d   = inx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          div_d  = bus.op2;
          rem_d  = {1'b0, bus.op1};
          cnt_d  = CNT_W'(Q_W - 1);
          quot_d = '0;
          dz_d   = 1'b0;
          ovf_d  = 1'b0;
          inx_d  = 1'b0;
          if (w_in_dz) begin
            quot_d  = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else if (w_in_ovf) begin
            quot_d  = '1;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        quot_d = quot_q | (Q_W'(w_ge) << cnt_q);
        rem_d  = w_rem_shl;
        if (cnt_q == '0) begin
          // Inexact is judged on the remainder before the final shift.
          inx_d   = (w_rem_sub != '0);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      inx_q   <= inx_d;
    end
  end

  // in_ready depends only on state, never on out_ready.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = quot_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;
  assign bus.inexact   = inx_q;

endmodule
`default_nettype wire
